// File: rtl/kbd_scan.sv
// 4x3 keypad matrix scanner: column drive, row synchronisation, per-frame debounce
// and a small key FIFO read by the downstream Wishbone slave via valid/pop.
module kbd_scan #(
  parameter int clk_freq        = 100000000,
  parameter int scan_hz         = 1000,
  parameter int debounce_frames = 4,
  parameter int fifo_depth      = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [2:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_pop,
  output logic       key_held,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int DIV = clk_freq / scan_hz;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(fifo_depth);
  localparam int CW  = PW + 1;
  localparam logic [TW-1:0] TICK_MAX   = TW'(DIV - 1);
  localparam logic [3:0]    STABLE_MAX = 4'(debounce_frames);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(fifo_depth);
  localparam logic [3:0]    NONE  = 4'hF;
  localparam logic [3:0]    MULTI = 4'hE;

  typedef enum logic {IDLE, HELD} state_t;

  logic [2:0]    row_s1, row_s2;
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic          tick_end, frame_end;
  logic [1:0]    acc_cnt, col_hits, tot_cnt;
  logic [3:0]    acc_code, col_code, tot_code;
  logic [2:0]    hit_sum;
  logic [3:0]    cand, prev_cand, stable_cnt, stable_nxt;
  state_t        state_q, state_d;
  logic          push_req;
  logic [3:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          pop_ok, push_ok, full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= 3'b111;
      row_s2 <= 3'b111;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  assign tick_end  = (tick == TICK_MAX);
  assign frame_end = tick_end && (col_idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick    <= '0;
      col_idx <= 2'd0;
      col_out <= 4'b1110;
    end else if (tick_end) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
      col_out <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Fold the current column's sample into the frame totals; 2 means "two or more keys".
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'd0;
    for (int r = 0; r < 3; r++) begin
      if (!row_s2[r]) begin
        col_hits = col_hits + 2'd1;
        col_code = 4'(col_idx) * 4'd3 + 4'(r);
      end
    end
    hit_sum  = {1'b0, acc_cnt} + {1'b0, col_hits};
    tot_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code = (acc_cnt == 2'd1) ? acc_code : col_code;
    cand     = (tot_cnt == 2'd0) ? NONE : (tot_cnt == 2'd1) ? tot_code : MULTI;
    if (cand == prev_cand)
      stable_nxt = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
    else
      stable_nxt = 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      prev_cand  <= NONE;
      stable_cnt <= 4'd0;
    end else if (frame_end) begin
      acc_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      prev_cand  <= cand;
      stable_cnt <= stable_nxt;
    end else if (tick_end) begin
      acc_cnt  <= tot_cnt;
      acc_code <= tot_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // One push per debounced press; a release must be seen before the next push.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: if (cand < 4'd12 && stable_nxt == STABLE_MAX) begin
          push_req = 1'b1;
          state_d  = HELD;
        end
        HELD: if (cand == NONE && stable_nxt == STABLE_MAX) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_held = (state_q == HELD);

  always_comb begin
    pop_ok     = key_pop && (count != '0);
    full       = (count == FIFO_FULL);
    push_ok    = push_req && (!full || pop_ok);
    rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cand;
  end

  // The head register must see a code written on this same edge when it becomes the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      key_valid <= (count_nxt != '0);
      if (count_nxt == '0)
        key_code <= 4'd0;
      else if (push_ok && rd_ptr_nxt == wr_ptr)
        key_code <= cand;
      else
        key_code <= mem[rd_ptr_nxt];
      if (push_req && full && !pop_ok) overflow <= 1'b1;
      else if (clr_ovf)                overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_scan.sv
// Bench for kbd_scan: a keypad model drives the rows, a frame-level model predicts pushes
// into an expected-FIFO queue, and pops/frame ends are compared against it.
module tb_kbd_scan;

  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_out;
  logic [2:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid, key_pop, key_held, overflow, clr_ovf;

  logic [11:0] key_vec;
  logic [3:0]  exp_q[$];
  logic [3:0]  m_prev, m_stable;
  logic        m_held, m_ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  kbd_scan #(
    .clk_freq(1000), .scan_hz(100), .debounce_frames(DEB), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .col_out(col_out), .row_in(row_in),
    .key_code(key_code), .key_valid(key_valid), .key_pop(key_pop),
    .key_held(key_held), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 3'b111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 3; r++)
        if (!col_out[c] && key_vec[3*c+r]) row_in[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] frame_cand(input logic [11:0] keys);
    logic [3:0] res;
    res = 4'hF;
    if ($countones(keys) > 1) res = 4'hE;
    else for (int i = 0; i < 12; i++) if (keys[i]) res = 4'(i);
    return res;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_prev   = 4'hF;
    m_stable = 4'd0;
    m_held   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_status(input string where);
    checkOutput({where, "_held"},  key_held,  m_held);
    checkOutput({where, "_valid"}, key_valid, exp_q.size() != 0);
    checkOutput({where, "_code"},  key_code,  (exp_q.size() != 0) ? exp_q[0] : 4'd0);
    checkOutput({where, "_ovf"},   overflow,  m_ovf);
  endtask

  // One full scan frame with a fixed key set; optional pops early in the frame,
  // a pop on the frame-end edge, and an overflow clear on the first cycle.
  task automatic applyStimulus(input logic [11:0] keys, input int npops, input bit pop_end, input bit clr);
    logic [3:0] cand, exp_col;
    key_vec = keys;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      key_pop = 1'b0;
      clr_ovf = 1'b0;
      if (i % 10 == 5) begin
        exp_col = ~(4'b0001 << (i / 10));
        checkOutput("col_out", col_out, exp_col);
      end
      if (clr && i == 0) begin
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
      end
      if (i < npops || (pop_end && i == FRAME - 1)) begin
        checkOutput("pop_valid", key_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          checkOutput("pop_code", key_code, exp_q[0]);
          void'(exp_q.pop_front());
        end
        key_pop = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    key_pop = 1'b0;
    clr_ovf = 1'b0;
    cand = frame_cand(keys);
    if (cand == m_prev) m_stable = (m_stable >= DEB) ? 4'(DEB) : m_stable + 4'd1;
    else                m_stable = 4'd1;
    m_prev = cand;
    if (!m_held && cand < 4'd12 && m_stable == DEB) begin
      m_held = 1'b1;
      if (exp_q.size() < DEPTH) exp_q.push_back(cand);
      else                      m_ovf = 1'b1;
    end else if (m_held && cand == 4'hF && m_stable == DEB) begin
      m_held = 1'b0;
    end
    check_status("frame");
  endtask

  task automatic press_release(input int code);
    repeat (DEB) applyStimulus(12'd1 << code, 0, 1'b0, 1'b0);
    repeat (DEB) applyStimulus(12'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string where);
    checkOutput({where, "_col"},   col_out,   4'b1110);
    checkOutput({where, "_valid"}, key_valid, 1'b0);
    checkOutput({where, "_code"},  key_code,  4'd0);
    checkOutput({where, "_held"},  key_held,  1'b0);
    checkOutput({where, "_ovf"},   overflow,  1'b0);
  endtask

  initial begin
    rst = 1'b0;
    key_vec = 12'd0;
    key_pop = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    applyStimulus(12'd0, 0, 1'b0, 1'b0);

    // Single key 7 held three frames, released, popped, then a pop on an empty FIFO.
    repeat (3) applyStimulus(12'd1 << 7, 0, 1'b0, 1'b0);
    repeat (2) applyStimulus(12'd0, 0, 1'b0, 1'b0);
    applyStimulus(12'd0, 1, 1'b0, 1'b0);
    applyStimulus(12'd0, 1, 1'b0, 1'b0);

    // Too short, then bouncing: neither may push.
    applyStimulus(12'd1 << 5, 0, 1'b0, 1'b0);
    repeat (2) applyStimulus(12'd0, 0, 1'b0, 1'b0);
    repeat (3) begin
      applyStimulus(12'd1 << 3, 0, 1'b0, 1'b0);
      applyStimulus(12'd0, 0, 1'b0, 1'b0);
    end
    applyStimulus(12'd0, 0, 1'b0, 1'b0);

    // Two keys held, then the second released.
    repeat (3) applyStimulus((12'd1 << 0) | (12'd1 << 4), 0, 1'b0, 1'b0);
    repeat (2) applyStimulus(12'd1 << 0, 0, 1'b0, 1'b0);
    repeat (2) applyStimulus(12'd0, 0, 1'b0, 1'b0);
    applyStimulus(12'd0, 1, 1'b0, 1'b0);

    // Five presses with no pops: the fifth overflows; drain, then clear overflow.
    press_release(1);
    press_release(2);
    press_release(3);
    press_release(5);
    press_release(6);
    applyStimulus(12'd0, 4, 1'b0, 1'b0);
    applyStimulus(12'd0, 0, 1'b0, 1'b1);

    // Fill the FIFO, then pop on the same edge as a new push.
    press_release(8);
    press_release(9);
    press_release(10);
    press_release(11);
    applyStimulus(12'd1 << 2, 0, 1'b0, 1'b0);
    applyStimulus(12'd1 << 2, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame with the FIFO full and a key held.
    repeat (17) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    key_vec = 12'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(12'd0, 0, 1'b0, 1'b0);
    press_release(4);
    applyStimulus(12'd0, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
